multicycle_control: RTL

Multi-cycle sequencer for the LEGv8 CPU datapath. It latches the opcode of each fetched instruction and steps through FETCH/DECODE/EXEC/MEM/WB. In each state it drives the control bundle consumed by the Execution stage: ALUSrc, ALUOp, B/BZ/BNZ, MemRead, MemWrite, MemtoReg and RegWrite. It also drives PC/IR write enables, a req/ack memory handshake, a timeout guard and a retired-instruction counter.

---
 rtl/cpu_ctrl_pkg.sv | 132 +++++++++++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/opcode_class_decode.sv | 38 +++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the LEGv8 multi-cycle control unit: sequencer
// state encoding, instruction class enum, opcode match/mask constants,
// ALUSrc/ALUOp codes, fault codes and the control bundle type together
// with the function that maps (state, class) onto that bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // CLS_ILLEGAL is the all-zero value so a cleared class register reads as illegal.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_ITYPE   = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_CBZ     = 3'd5,
    CLS_CBNZ    = 3'd6,
    CLS_UNCOND  = 3'd7
  } op_class_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_t;

  localparam logic [1:0] ALUSRC_REG   = 2'b00;
  localparam logic [1:0] ALUSRC_SEXT  = 2'b01;
  localparam logic [1:0] ALUSRC_IMM12 = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNC   = 2'b10;

  // Opcode match values; a mask bit of 0 marks a don't-care position.
  localparam logic [10:0] MASK_ALL  = 11'h7FF;
  localparam logic [10:0] OP_ADD    = 11'h458;
  localparam logic [10:0] OP_SUB    = 11'h658;
  localparam logic [10:0] OP_AND    = 11'h450;
  localparam logic [10:0] OP_ORR    = 11'h550;
  localparam logic [10:0] OP_ADDI   = 11'h488;
  localparam logic [10:0] OP_SUBI   = 11'h688;
  localparam logic [10:0] MASK_IMM  = 11'h7FE;
  localparam logic [10:0] OP_MOVZ   = 11'h694;
  localparam logic [10:0] MASK_MOVZ = 11'h7FC;
  localparam logic [10:0] OP_LDUR   = 11'h7C2;
  localparam logic [10:0] OP_STUR   = 11'h7C0;
  localparam logic [10:0] OP_CBZ    = 11'h5A0;
  localparam logic [10:0] OP_CBNZ   = 11'h5A8;
  localparam logic [10:0] MASK_CB   = 11'h7F8;
  localparam logic [10:0] OP_B      = 11'h0A0;
  localparam logic [10:0] MASK_B    = 11'h7E0;

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic [1:0] alu_src;
    logic [1:0] alu_op;
    logic       b;
    logic       bz;
    logic       bnz;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic logic is_branch(input op_class_t c);
    return (c == CLS_CBZ) || (c == CLS_CBNZ) || (c == CLS_UNCOND);
  endfunction

  // Control bundle presented while the sequencer sits in state s with class c.
  // The ack-dependent IRWrite and store PCWrite are added by the top level.
  function automatic ctrl_t ctrl_for(input state_t s, input op_class_t c);
    ctrl_t ctl;
    ctl = '0;
    if ((s == S_EXEC) || (s == S_MEM) || (s == S_WB)) begin
      case (c)
        CLS_RTYPE: begin
          ctl.alu_src = ALUSRC_REG;
          ctl.alu_op  = ALUOP_FUNC;
        end
        CLS_ITYPE: begin
          ctl.alu_src = ALUSRC_IMM12;
          ctl.alu_op  = ALUOP_FUNC;
        end
        CLS_LOAD, CLS_STORE: begin
          ctl.alu_src = ALUSRC_SEXT;
          ctl.alu_op  = ALUOP_ADD;
        end
        CLS_CBZ, CLS_CBNZ, CLS_UNCOND: begin
          ctl.alu_src = ALUSRC_REG;
          ctl.alu_op  = ALUOP_BRANCH;
        end
        default: ;
      endcase
    end
    case (s)
      S_FETCH: begin
        ctl.mem_req  = 1'b1;
        ctl.mem_read = 1'b1;
      end
      S_EXEC: begin
        ctl.b        = (c == CLS_UNCOND);
        ctl.bz       = (c == CLS_CBZ);
        ctl.bnz      = (c == CLS_CBNZ);
        ctl.pc_write = is_branch(c);
      end
      S_MEM: begin
        ctl.mem_req   = 1'b1;
        ctl.mem_read  = (c == CLS_LOAD);
        ctl.mem_write = (c == CLS_STORE);
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.pc_write   = 1'b1;
        ctl.mem_to_reg = (c == CLS_LOAD);
      end
      default: ;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Bundle between the multi-cycle control unit and the LEGv8 datapath/memory.
//   Opcode   : Instruction[31:21] from the IR input
//   mem_ack  : memory completion
//   mem_req  : memory request (fetch or data access)
//   IRWrite, PCWrite, ALUSrc, ALUOp, B, BZ, BNZ,
//   MemRead, MemWrite, MemtoReg, RegWrite : datapath controls
// master = control unit, slave = datapath side.
interface multicycle_control_if;
  logic [10:0] Opcode;
  logic        mem_ack;
  logic        mem_req;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  ALUSrc;
  logic [1:0]  ALUOp;
  logic        B;
  logic        BZ;
  logic        BNZ;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;

  modport master (
    input  Opcode, mem_ack,
    output mem_req, IRWrite, PCWrite, ALUSrc, ALUOp, B, BZ, BNZ,
           MemRead, MemWrite, MemtoReg, RegWrite
  );

  modport slave (
    output Opcode, mem_ack,
    input  mem_req, IRWrite, PCWrite, ALUSrc, ALUOp, B, BZ, BNZ,
           MemRead, MemWrite, MemtoReg, RegWrite
  );
endinterface

// File: rtl/opcode_class_decode.sv
// opcode_class_decode
// Purely combinational classifier: 11-bit LEGv8 opcode -> instruction class.
//   opcode   in  11 : Instruction[31:21]
//   op_class out  3 : class, CLS_ILLEGAL when no pattern matches
module opcode_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output op_class_t   op_class
);

  function automatic logic hit(input logic [10:0] op, input logic [10:0] match,
                               input logic [10:0] mask);
    return (op & mask) == match;
  endfunction

  // Patterns never overlap, so the priority order below is irrelevant.
  always_comb begin
    op_class = CLS_ILLEGAL;
    if (hit(opcode, OP_ADD, MASK_ALL) || hit(opcode, OP_SUB, MASK_ALL) ||
        hit(opcode, OP_AND, MASK_ALL) || hit(opcode, OP_ORR, MASK_ALL))
      op_class = CLS_RTYPE;
    else if (hit(opcode, OP_ADDI, MASK_IMM) || hit(opcode, OP_SUBI, MASK_IMM) ||
             hit(opcode, OP_MOVZ, MASK_MOVZ))
      op_class = CLS_ITYPE;
    else if (hit(opcode, OP_LDUR, MASK_ALL))
      op_class = CLS_LOAD;
    else if (hit(opcode, OP_STUR, MASK_ALL))
      op_class = CLS_STORE;
    else if (hit(opcode, OP_CBZ, MASK_CB))
      op_class = CLS_CBZ;
    else if (hit(opcode, OP_CBNZ, MASK_CB))
      op_class = CLS_CBNZ;
    else if (hit(opcode, OP_B, MASK_B))
      op_class = CLS_UNCOND;
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 datapath.
//   clk         in          : clock
//   reset       in          : synchronous, active-high
//   bus         master      : opcode/ack in, memory request and datapath controls out
//   state       out 3       : current sequencer state (debug)
//   halted      out 1       : sticky fault flag, cleared only by reset
//   fault_code  out 2       : 00 none, 01 illegal opcode, 10 memory timeout
//   instr_count out CNT_W   : retired instructions, wraps
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [1:0]            fault_code,
  output logic [CNT_W-1:0]      instr_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t             state_q;
  op_class_t          cls_q;
  op_class_t          cls_dec;
  ctrl_t              ctrl_q;
  fault_t             fault_q;
  logic               halted_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   count_q;

  logic acked;
  logic waiting;
  logic timed_out;
  logic store_ack;

  opcode_class_decode u_decode (
    .opcode   (bus.Opcode),
    .op_class (cls_dec)
  );

  // An ack only counts while a request is actually being presented; this also
  // ignores acks in the idle cycle straight after reset, where mem_req is still 0.
  assign acked     = ctrl_q.mem_req & bus.mem_ack;
  assign waiting   = ctrl_q.mem_req & ~bus.mem_ack;
  assign timed_out = waiting & (wait_q == WAIT_W'(TIMEOUT - 1));
  assign store_ack = (state_q == S_MEM) & (cls_q == CLS_STORE) & acked;

  // One-process sequencer. Controls are registered as the bundle of the state
  // being entered, so they line up with state_q and are all 0 right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cls_q    <= CLS_ILLEGAL;
      ctrl_q   <= '0;
      fault_q  <= FAULT_NONE;
      halted_q <= 1'b0;
      wait_q   <= '0;
      count_q  <= '0;
    end else begin
      if (waiting) wait_q <= wait_q + WAIT_W'(1);
      case (state_q)
        S_FETCH: begin
          if (acked) begin
            state_q <= S_DECODE;
            cls_q   <= cls_dec;
            ctrl_q  <= ctrl_for(S_DECODE, cls_dec);
          end else if (timed_out) begin
            state_q  <= S_HALT;
            ctrl_q   <= '0;
            halted_q <= 1'b1;
            fault_q  <= FAULT_TIMEOUT;
          end else begin
            ctrl_q <= ctrl_for(S_FETCH, cls_q);
          end
        end
        S_DECODE: begin
          if (cls_q == CLS_ILLEGAL) begin
            state_q  <= S_HALT;
            ctrl_q   <= '0;
            halted_q <= 1'b1;
            fault_q  <= FAULT_ILLEGAL;
          end else begin
            state_q <= S_EXEC;
            ctrl_q  <= ctrl_for(S_EXEC, cls_q);
          end
        end
        S_EXEC: begin
          if (is_branch(cls_q)) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for(S_FETCH, cls_q);
            wait_q  <= '0;
            count_q <= count_q + CNT_W'(1);
          end else if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) begin
            state_q <= S_MEM;
            ctrl_q  <= ctrl_for(S_MEM, cls_q);
            wait_q  <= '0;
          end else begin
            state_q <= S_WB;
            ctrl_q  <= ctrl_for(S_WB, cls_q);
          end
        end
        S_MEM: begin
          if (acked) begin
            if (cls_q == CLS_LOAD) begin
              state_q <= S_WB;
              ctrl_q  <= ctrl_for(S_WB, cls_q);
            end else begin
              state_q <= S_FETCH;
              ctrl_q  <= ctrl_for(S_FETCH, cls_q);
              wait_q  <= '0;
              count_q <= count_q + CNT_W'(1);
            end
          end else if (timed_out) begin
            state_q  <= S_HALT;
            ctrl_q   <= '0;
            halted_q <= 1'b1;
            fault_q  <= FAULT_TIMEOUT;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          ctrl_q  <= ctrl_for(S_FETCH, cls_q);
          wait_q  <= '0;
          count_q <= count_q + CNT_W'(1);
        end
        S_HALT: begin
          ctrl_q <= '0;
        end
        default: begin
          state_q  <= S_HALT;
          ctrl_q   <= '0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // IRWrite and the store's PC update are the only outputs that follow mem_ack
  // combinationally: both must happen in the ack cycle itself, which is the
  // last cycle of the state, so the PC is written exactly once per store.
  assign bus.mem_req  = ctrl_q.mem_req;
  assign bus.IRWrite  = (state_q == S_FETCH) & acked;
  assign bus.PCWrite  = ctrl_q.pc_write | store_ack;
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.ALUOp    = ctrl_q.alu_op;
  assign bus.B        = ctrl_q.b;
  assign bus.BZ       = ctrl_q.bz;
  assign bus.BNZ      = ctrl_q.bnz;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.MemtoReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = ctrl_q.reg_write;

  assign state       = state_q;
  assign halted      = halted_q;
  assign fault_code  = fault_q;
  assign instr_count = count_q;

endmodule
